// File: rtl/regfile_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter: round-robin write-back arbiter for the regfile port, |
// | with a pending scoreboard of registers claimed by the multi-cycle unit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_stall_i,
   input  logic                   a_valid_i,
   input  logic [ADDR_W-1:0]      a_addr_i,
   input  logic [DATA_W-1:0]      a_data_i,
   output logic                   a_ready_o,
   input  logic                   b_valid_i,
   input  logic [ADDR_W-1:0]      b_addr_i,
   input  logic [DATA_W-1:0]      b_data_i,
   output logic                   b_ready_o,
   input  logic                   claim_valid_i,
   input  logic [ADDR_W-1:0]      claim_addr_i,
   output logic                   wr_en_o,
   output logic [ADDR_W-1:0]      wr_addr_o,
   output logic [DATA_W-1:0]      wr_data_o,
   output logic [(2**ADDR_W)-1:0] pend_o
);

   localparam int NREG = 2**ADDR_W;

   typedef enum logic [0:0] {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

   prio_e             prio_q, prio_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [NREG-1:0]   pend_q, pend_d;

   logic              w_a_xfer;
   logic              w_b_xfer;
   logic [NREG-1:0]   w_pend_set;
   logic [NREG-1:0]   w_pend_clr;

   // Each ready depends only on valids and prio, so the two can never both be high.
   always_comb begin
      a_ready_o = 1'b0;
      b_ready_o = 1'b0;
      if (!reset && !wb_stall_i) begin
         a_ready_o = a_valid_i & (~b_valid_i | (prio_q == PRIO_A));
         b_ready_o = b_valid_i & (~a_valid_i | (prio_q == PRIO_B));
      end
   end

   assign w_a_xfer = a_valid_i & a_ready_o;
   assign w_b_xfer = b_valid_i & b_ready_o;

   always_comb begin
      prio_d    = prio_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (w_a_xfer) begin
         prio_d    = PRIO_B;
         wr_en_d   = |a_addr_i;
         wr_addr_d = a_addr_i;
         wr_data_d = a_data_i;
      end else if (w_b_xfer) begin
         prio_d    = PRIO_A;
         wr_en_d   = |b_addr_i;
         wr_addr_d = b_addr_i;
         wr_data_d = b_data_i;
      end
   end

   // Set is OR-ed after the clear so a same-cycle re-claim keeps the bit pending.
   always_comb begin
      w_pend_set = '0;
      w_pend_clr = '0;
      if (claim_valid_i && (claim_addr_i != '0)) begin
         w_pend_set[claim_addr_i] = 1'b1;
      end
      if (w_b_xfer) begin
         w_pend_clr[b_addr_i] = 1'b1;
      end
      pend_d = (pend_q & ~w_pend_clr) | w_pend_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q    <= PRIO_A;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pend_q    <= '0;
      end else begin
         prio_q    <= prio_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         pend_q    <= pend_d;
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign pend_o    = pend_q;

endmodule

`default_nettype wire
